// File: rtl/mem_rd_arbiter.sv
// rtl/mem_rd_arbiter.sv - round-robin arbiter sharing one memory read port among cache requesters
// One burst in flight: grant, issue the latched request, then steer beats to the winner until last.
module mem_rd_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     from_req_valid,
   input  logic [32*NUM_REQ-1:0]  from_req_addr,
   input  logic [8*NUM_REQ-1:0]   from_req_len,
   output logic [NUM_REQ-1:0]     to_req_ready,
   output logic [NUM_REQ-1:0]     to_req_rsp_valid,
   output logic [31:0]            to_req_rsp_data,
   output logic                   to_req_rsp_last,
   input  logic [NUM_REQ-1:0]     from_req_rsp_ready,
   output logic                   to_mem_rd_req_valid,
   output logic [31:0]            to_mem_rd_req_addr,
   output logic [7:0]             to_mem_rd_req_len,
   input  logic                   from_mem_rd_req_ready,
   input  logic                   from_mem_rd_rsp_valid,
   input  logic [31:0]            from_mem_rd_rsp_data,
   input  logic                   from_mem_rd_rsp_last,
   output logic                   to_mem_rd_rsp_ready
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [PTR_W-1:0] r_gnt;
   logic [PTR_W-1:0] r_rr_ptr;
   logic [PTR_W-1:0] w_sel;
   logic [PTR_W-1:0] w_rr_nxt;
   logic             w_found;
   logic             w_beat;
   logic [31:0]      r_addr_q;
   logic [7:0]       r_len_q;
   logic [7:0]       r_beat_cnt;

   // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      w_found = 1'b0;
      w_sel   = r_rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && from_req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
            w_found = 1'b1;
            w_sel   = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
         end
      end
      w_rr_nxt = PTR_W'((int'(w_sel) + 1) % NUM_REQ);
   end

   always_comb begin
      w_state_nxt         = r_state;
      w_beat              = 1'b0;
      to_req_ready        = '0;
      to_req_rsp_valid    = '0;
      to_req_rsp_data     = '0;
      to_req_rsp_last     = 1'b0;
      to_mem_rd_req_valid = 1'b0;
      to_mem_rd_req_addr  = '0;
      to_mem_rd_req_len   = '0;
      to_mem_rd_rsp_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            // rst gate keeps the combinational accept silent while reset is held
            if (w_found && rst) begin
               to_req_ready[w_sel] = 1'b1;
               w_state_nxt         = S_REQ;
            end
         end
         S_REQ: begin
            to_mem_rd_req_valid = 1'b1;
            to_mem_rd_req_addr  = r_addr_q;
            to_mem_rd_req_len   = r_len_q;
            if (from_mem_rd_req_ready) w_state_nxt = S_RSP;
         end
         S_RSP: begin
            to_req_rsp_valid[r_gnt] = from_mem_rd_rsp_valid;
            to_req_rsp_data         = from_mem_rd_rsp_data;
            to_req_rsp_last         = from_mem_rd_rsp_last;
            to_mem_rd_rsp_ready     = from_req_rsp_ready[r_gnt];
            w_beat                  = from_mem_rd_rsp_valid && from_req_rsp_ready[r_gnt];
            if (w_beat && from_mem_rd_rsp_last) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_gnt      <= '0;
         r_rr_ptr   <= '0;
         r_addr_q   <= '0;
         r_len_q    <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && w_found) begin
            r_gnt      <= w_sel;
            r_addr_q   <= from_req_addr[32*w_sel +: 32];
            r_len_q    <= from_req_len[8*w_sel +: 8];
            r_rr_ptr   <= w_rr_nxt;
            r_beat_cnt <= '0;
         end
         if (w_beat) r_beat_cnt <= r_beat_cnt + 8'd1;
      end
   end

   // The burst is ended by last alone; the counter only confirms memory honoured the length.
   a_beat_cnt: assert property (@(posedge clk) disable iff (!rst)
      (w_beat && from_mem_rd_rsp_last) |-> (r_beat_cnt == r_len_q));

endmodule
